// File: rtl/shift_pkg.sv
// shift_pkg: shared types and constants for the shift sequencer and its step datapath.
package shift_pkg;

  // Positions the step datapath can move in one cycle.
  localparam int STEP_MAX = 3;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_t;

endpackage

// File: rtl/shift_step.sv
// shift_step: combinational single-step shifter, moves 0..3 positions per call.
// Carry is the last bit pushed out by this step (0 when k==0).
module shift_step
  import shift_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] data,
  input  shift_op_t     op,
  input  logic [1:0]    k,
  output logic [DW-1:0] result,
  output logic          carry
);

  logic signed [DW-1:0] w_sdata;
  logic [2*DW-1:0]      w_rot;
  logic [DW:0]          w_lsl_full;
  logic [DW:0]          w_lsr_full;

  assign w_sdata    = data;
  assign w_rot      = {data, data} >> k;
  // Extra bit above/below the operand catches the bit that leaves on the far side.
  assign w_lsl_full = {1'b0, data} << k;
  assign w_lsr_full = {data, 1'b0} >> k;

  // Select the shifted value and the bit that fell off for the requested operation.
  always_comb begin
    result = data;
    carry  = 1'b0;
    case (op)
      LSL: begin
        result = data << k;
        carry  = w_lsl_full[DW];
      end
      LSR: begin
        result = data >> k;
        carry  = w_lsr_full[0];
      end
      ASR: begin
        result = w_sdata >>> k;
        carry  = w_lsr_full[0];
      end
      ROR: begin
        result = w_rot[DW-1:0];
        carry  = (k != 2'd0) ? w_rot[DW-1] : 1'b0;
      end
      default: begin
        result = data;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle shift/rotate sequencer with valid/ready on both sides.
// One operation in flight; each RUN cycle applies shift_step by min(rem, 3).
// Optional: define SHIFT_SEQ_FLAGS_EN to add out_carry / out_zero result flags.
module shift_seq
  import shift_pkg::*;
#(
  parameter int DW    = 8,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
`ifdef SHIFT_SEQ_FLAGS_EN
  output logic             out_carry,
  output logic             out_zero,
`endif
  output logic             busy
);

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  logic [DW-1:0]    r_data;
  shift_op_t        r_op;
  logic [AMT_W-1:0] r_rem;
  logic             r_out_valid;
  logic [DW-1:0]    r_out_data;
  logic             r_busy;

  logic             w_accept;
  logic             w_last;
  logic [1:0]       w_k;
  logic [DW-1:0]    w_step_result;
  logic             w_step_carry;

  // in_ready must read low for the whole time reset is held, even though state sits at IDLE.
  assign in_ready  = reset_n && (r_state == IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_rem <= AMT_W'(STEP_MAX));
  assign w_k       = w_last ? r_rem[1:0] : 2'(STEP_MAX);

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

  shift_step #(.DW(DW)) u_step (
    .data   (r_data),
    .op     (r_op),
    .k      (w_k),
    .result (w_step_result),
    .carry  (w_step_carry)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state decode: accept in IDLE, step in RUN, wait for the consumer in DONE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next_state = (in_amt == '0) ? DONE : RUN;
      RUN:  if (w_last)   w_next_state = DONE;
      DONE: if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Operand/remaining-count datapath plus registered result and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data      <= '0;
      r_op        <= LSL;
      r_rem       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
`ifdef SHIFT_SEQ_FLAGS_EN
      out_carry   <= 1'b0;
      out_zero    <= 1'b0;
`endif
    end else begin
      r_out_valid <= (w_next_state == DONE);
      r_busy      <= (w_next_state != IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_data <= in_data;
            r_op   <= shift_op_t'(in_op);
            r_rem  <= in_amt;
            // A zero-amount request is complete as soon as it is accepted.
            if (in_amt == '0) begin
              r_out_data <= in_data;
`ifdef SHIFT_SEQ_FLAGS_EN
              out_carry  <= 1'b0;
              out_zero   <= (in_data == '0);
`endif
            end
          end
        end
        RUN: begin
          r_data <= w_step_result;
          r_rem  <= r_rem - AMT_W'(w_k);
          if (w_last) begin
            r_out_data <= w_step_result;
`ifdef SHIFT_SEQ_FLAGS_EN
            out_carry  <= w_step_carry;
            out_zero   <= (w_step_result == '0);
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifndef SHIFT_SEQ_FLAGS_EN
  logic w_unused_carry;
  assign w_unused_carry = w_step_carry;
`endif

endmodule
